// File: rtl/regfile_dumper_pkg.sv
// Shared widths, state encoding and stream payload for the register-file dump engine.
package regfile_dumper_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } dump_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
        logic                  last;
    } dump_word_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Register-file rs read port plus valid/ready dump stream, seen from the dumper (master).
interface regfile_dumper_if;
    import regfile_dumper_pkg::*;

    logic                  out_rs_rena;
    logic [REG_ADDR_W-1:0] out_rs_addr;
    logic [REG_DATA_W-1:0] in_rs_data;
    logic                  out_valid;
    logic                  in_ready;
    logic [REG_DATA_W-1:0] out_data;
    logic [REG_ADDR_W-1:0] out_addr;
    logic                  out_last;

    modport master (
        output out_rs_rena, out_rs_addr,
        input  in_rs_data,
        output out_valid, out_data, out_addr, out_last,
        input  in_ready
    );

    modport slave (
        input  out_rs_rena, out_rs_addr,
        output in_rs_data,
        input  out_valid, out_data, out_addr, out_last,
        output in_ready
    );

endinterface

// File: rtl/regfile_dumper.sv
// Walks FIRST_ADDR..LAST_ADDR through the register-file rs port and streams each word
// out over valid/ready; one read in flight, one word every two cycles at full rate.
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    output logic             out_busy,
    output logic             out_done,
    regfile_dumper_if.master bus
);

    if (!(FIRST_ADDR <= LAST_ADDR && LAST_ADDR < REG_COUNT)) begin : g_bad_range
        $error("regfile_dumper: need FIRST_ADDR <= LAST_ADDR <= 31");
    end

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_ADDR);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_ADDR);

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    logic                  rena_q, rena_d;
    logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic                  valid_q, valid_d;
    dump_word_t            word_q, word_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // State and output registers; reset aborts any dump without a done pulse.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rena_q    <= 1'b0;
            rs_addr_q <= '0;
            valid_q   <= 1'b0;
            word_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rena_q    <= rena_d;
            rs_addr_q <= rs_addr_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rena_d    = rena_q;
        rs_addr_d = rs_addr_q;
        valid_d   = valid_q;
        word_d    = word_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d   = ISSUE;
                    cnt_d     = FIRST_A;
                    rena_d    = 1'b1;
                    rs_addr_d = FIRST_A;
                end
            end
            ISSUE: begin
                // Read data for the address issued last cycle is valid now.
                state_d     = HOLD;
                word_d.addr = cnt_q;
                word_d.data = bus.in_rs_data;
                word_d.last = (cnt_q == LAST_A);
                valid_d     = 1'b1;
                rena_d      = 1'b0;
            end
            HOLD: begin
                if (valid_q && bus.in_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q == LAST_A) begin
                        word_d.last = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d     = cnt_q + REG_ADDR_W'(1);
                        rena_d    = 1'b1;
                        rs_addr_d = cnt_q + REG_ADDR_W'(1);
                        state_d   = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rena_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.out_rs_rena = rena_q;
    assign bus.out_rs_addr = rs_addr_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_data    = word_q.data;
    assign bus.out_addr    = word_q.addr;
    assign bus.out_last    = word_q.last;
    assign out_busy        = busy_q;
    assign out_done        = done_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: full-range instance plus a 4..6 instance,
// both reading a behavioural register file that answers on the negedge.
module tb_regfile_dumper;
    import regfile_dumper_pkg::*;

    logic in_clk = 1'b0;
    logic in_rst;
    logic start_a, start_b, ready_a, ready_b;
    logic busy_a, done_a, busy_b, done_b;
    logic [31:0] rd_a, rd_b;
    logic [31:0] regs [32];

    int n_vec = 0;
    int n_bad = 0;

    always #5 in_clk = ~in_clk;

    regfile_dumper_if bus_a ();
    regfile_dumper_if bus_b ();

    assign bus_a.in_ready   = ready_a;
    assign bus_a.in_rs_data = rd_a;
    assign bus_b.in_ready   = ready_b;
    assign bus_b.in_rs_data = rd_b;

    regfile_dumper dut_a (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_start (start_a),
        .out_busy (busy_a),
        .out_done (done_a),
        .bus      (bus_a)
    );

    regfile_dumper #(.FIRST_ADDR(4), .LAST_ADDR(6)) dut_b (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_start (start_b),
        .out_busy (busy_b),
        .out_done (done_b),
        .bus      (bus_b)
    );

    // Register file rs port: address latched on the negedge, register 0 reads as zero.
    always @(negedge in_clk) begin
        if (bus_a.out_rs_rena)
            rd_a <= (bus_a.out_rs_addr == 5'd0) ? 32'd0 : regs[bus_a.out_rs_addr];
        if (bus_b.out_rs_rena)
            rd_b <= (bus_b.out_rs_addr == 5'd0) ? 32'd0 : regs[bus_b.out_rs_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic check_reset_a();
        check_b("rst_busy",  busy_a, 1'b0);
        check_b("rst_done",  done_a, 1'b0);
        check_b("rst_rena",  bus_a.out_rs_rena, 1'b0);
        check("rst_rs_addr", 32'(bus_a.out_rs_addr), 32'd0);
        check_b("rst_valid", bus_a.out_valid, 1'b0);
        check("rst_data",    bus_a.out_data, 32'd0);
        check("rst_addr",    32'(bus_a.out_addr), 32'd0);
        check_b("rst_last",  bus_a.out_last, 1'b0);
    endtask

    // Full 0..31 dump on dut_a. The reference is simply "registers FIRST..LAST in order,
    // each word equal to the register contents when it is read".
    // rmode: 0 ready always high, 1 random ready. spur: 0 none, 1 at cycles 3/7/20, 2 random.
    task automatic run_dump(input int rmode, input int stall_addr, input int inj_addr, input int spur);
        int exp_addr;
        int cyc;
        int stall;
        bit hs;
        bit fin;
        exp_addr = 0;
        cyc      = 0;
        stall    = 0;
        fin      = 1'b0;
        start_a  = 1'b1;
        ready_a  = 1'b1;
        @(posedge in_clk); #1;
        start_a = 1'b0;
        check_b("start_busy", busy_a, 1'b1);
        check_b("start_rena", bus_a.out_rs_rena, 1'b1);
        check("start_rs_addr", 32'(bus_a.out_rs_addr), 32'd0);
        while (!fin && cyc < 1000) begin
            if (bus_a.out_valid && stall_addr >= 0 && int'(bus_a.out_addr) == stall_addr && stall < 5) begin
                ready_a = 1'b0;
                stall++;
            end else if (rmode == 1) begin
                ready_a = 1'($urandom_range(0, 1));
            end else begin
                ready_a = 1'b1;
            end
            if (spur == 1)      start_a = (cyc == 3 || cyc == 7 || cyc == 20);
            else if (spur == 2) start_a = ($urandom_range(0, 3) == 0);
            else                start_a = 1'b0;
            // CPU write landing in the same cycle the read is issued
            if (inj_addr >= 0 && bus_a.out_rs_rena && int'(bus_a.out_rs_addr) == inj_addr)
                regs[inj_addr] = 32'hDEADBEEF;
            hs = bus_a.out_valid && ready_a;
            @(posedge in_clk); #1;
            cyc++;
            if (hs && exp_addr == 31) begin
                fin = 1'b1;
                check_b("done_pulse", done_a, 1'b1);
                check_b("busy_end", busy_a, 1'b0);
                check_b("valid_end", bus_a.out_valid, 1'b0);
                check_b("last_end", bus_a.out_last, 1'b0);
                if (rmode == 0 && stall_addr < 0)
                    check("dump_cycles", 32'(cyc), 32'd64);
            end else begin
                if (hs) exp_addr++;
                check_b("no_early_done", done_a, 1'b0);
                check_b("busy_mid", busy_a, 1'b1);
                if (bus_a.out_valid) begin
                    check("word_addr", 32'(bus_a.out_addr), 32'(exp_addr));
                    check("word_data", bus_a.out_data, regs[exp_addr]);
                    check_b("word_last", bus_a.out_last, exp_addr == 31);
                    check_b("no_read_while_valid", bus_a.out_rs_rena, 1'b0);
                    if (exp_addr == inj_addr)
                        check("fwd_data", bus_a.out_data, 32'hDEADBEEF);
                end
            end
        end
        check_b("dump_finished", fin, 1'b1);
        start_a = 1'b0;
        ready_a = 1'b1;
        @(posedge in_clk); #1;
        check_b("done_single", done_a, 1'b0);
    endtask

    typedef struct {
        bit          start;
        bit          ready;
        bit          busy;
        bit          rena;
        logic [4:0]  rs_addr;
        bit          valid;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          last;
        bit          done;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit hit;
        // Cycle-by-cycle dump of the 4..6 instance with a stall and an ignored start.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 5'd4, 32'd9, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 5'd4, 32'd9, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 32'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1, 5'd6, 32'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[2] = 32'd100;
        regs[3] = 32'd7;
        regs[4] = 32'd9;
        regs[5] = 32'd3;
        regs[6] = 32'd1;

        in_rst  = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
        check_reset_a();
        check_b("rst_b_busy",  busy_b, 1'b0);
        check_b("rst_b_valid", bus_b.out_valid, 1'b0);
        in_rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_b = tbl[i].start;
            ready_b = tbl[i].ready;
            @(posedge in_clk); #1;
            check_b($sformatf("tbl%0d_busy", i), busy_b, tbl[i].busy);
            check_b($sformatf("tbl%0d_rena", i), bus_b.out_rs_rena, tbl[i].rena);
            if (tbl[i].rena)
                check($sformatf("tbl%0d_rs_addr", i), 32'(bus_b.out_rs_addr), 32'(tbl[i].rs_addr));
            check_b($sformatf("tbl%0d_valid", i), bus_b.out_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_addr", i), 32'(bus_b.out_addr), 32'(tbl[i].addr));
                check($sformatf("tbl%0d_data", i), bus_b.out_data, tbl[i].data);
            end
            check_b($sformatf("tbl%0d_last", i), bus_b.out_last, tbl[i].last);
            check_b($sformatf("tbl%0d_done", i), done_b, tbl[i].done);
        end
        start_b = 1'b0;

        // Full-rate dump with start pulses while busy.
        run_dump(0, -1, -1, 1);
        // Five-cycle backpressure on register 4.
        run_dump(0, 4, -1, 0);

        // Reset in the middle of the dump at register 10.
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge in_clk); #1;
        start_a = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (bus_a.out_valid && bus_a.out_addr == 5'd10) hit = 1'b1;
            else begin @(posedge in_clk); #1; end
        end
        check_b("reach_addr10", hit, 1'b1);
        in_rst = 1'b1;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        check_reset_a();
        for (int i = 0; i < 3; i++) begin
            @(posedge in_clk); #1;
            check_b("no_done_after_abort", done_a, 1'b0);
            check_b("idle_after_abort", busy_a, 1'b0);
        end
        run_dump(0, -1, -1, 0);

        // Same-cycle CPU write to register 5 is forwarded into the dump.
        run_dump(0, -1, 5, 0);

        // Random contents, random backpressure, random ignored starts.
        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            run_dump(1, -1, -1, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
